// File: rtl/ocx_tlx_cmd_fifo_mac_gen2.sv
// TLX receive command buffer: speculative writes with CRC commit/rollback, a registered
// AFU/CFG routing stage, and TL command credit return (initial burst + one per pop).
module ocx_tlx_cmd_fifo_mac_gen2 #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          DATA_WIDTH = 168,
  parameter logic [7:0]  CFG_OPC0   = 8'hE0,
  parameter logic [7:0]  CFG_OPC1   = 8'hE1
) (
  input  logic                  tlx_clk,
  input  logic                  reset_n,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_commit,
  input  logic                  i_crc_error,
  input  logic                  i_afu_ready,
  input  logic                  i_cfg_ready,
  output logic                  o_afu_valid,
  output logic                  o_cfg_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_rcv_xmt_credit_v,
  output logic [ADDR_WIDTH:0]   o_fifo_count,
  output logic                  o_overflow_err
);

  localparam int             PW      = ADDR_WIDTH + 1;
  localparam int             DEPTH_N = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0]  DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]  PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PW-1:0]  PTR_ZERO = {PW{1'b0}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_N];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_cm_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_afu_valid;
  logic                  r_cfg_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_overflow_err;
  logic [PW-1:0]         r_credit_init_cnt;
  logic [PW-1:0]         r_credit_owed;

  logic                  w_spec_full;
  logic                  w_empty;
  logic                  w_wr_en;
  logic [PW-1:0]         w_wr_ptr_next;
  logic                  w_accept;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_is_cfg;
  logic                  w_credit_v;
  logic                  w_send_owed;

  // Pointer status, head decode and credit qualification
  always_comb begin
    w_spec_full   = (r_wr_ptr - r_rd_ptr) == DEPTH;
    w_empty       = (r_cm_ptr == r_rd_ptr);
    w_wr_en       = i_wr_valid & ~w_spec_full & ~i_crc_error;
    w_wr_ptr_next = w_wr_en ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    w_accept      = (r_afu_valid & i_afu_ready) | (r_cfg_valid & i_cfg_ready);
    w_load        = ~w_empty & (~(r_afu_valid | r_cfg_valid) | w_accept);
    w_head        = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    w_is_cfg      = (w_head[7:0] == CFG_OPC0) | (w_head[7:0] == CFG_OPC1);
    w_credit_v    = (r_credit_init_cnt != PTR_ZERO) | (r_credit_owed != PTR_ZERO);
    w_send_owed   = (r_credit_init_cnt == PTR_ZERO) & (r_credit_owed != PTR_ZERO);
  end

  // Command storage; no reset needed since only committed slots are ever read
  always_ff @(posedge tlx_clk) begin
    if (reset_n && w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
    end
  end

  // Speculative/committed/read pointers and sticky overflow flag
  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      r_wr_ptr       <= PTR_ZERO;
      r_cm_ptr       <= PTR_ZERO;
      r_rd_ptr       <= PTR_ZERO;
      r_overflow_err <= 1'b0;
    end else begin
      // A CRC error overrides any write or commit presented in the same cycle
      if (i_crc_error) begin
        r_wr_ptr <= r_cm_ptr;
      end else begin
        r_wr_ptr <= w_wr_ptr_next;
        if (i_wr_commit) begin
          r_cm_ptr <= w_wr_ptr_next;
        end
        if (i_wr_valid && w_spec_full) begin
          r_overflow_err <= 1'b1;
        end
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Registered output stage with opcode routing
  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      r_afu_valid <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_out_data  <= {DATA_WIDTH{1'b0}};
    end else if (w_load) begin
      r_out_data  <= w_head;
      r_cfg_valid <= w_is_cfg;
      r_afu_valid <= ~w_is_cfg;
    end else if (w_accept) begin
      r_afu_valid <= 1'b0;
      r_cfg_valid <= 1'b0;
    end
  end

  // Credit return: drain the initial burst first, then owed credits from pops
  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      r_credit_init_cnt <= DEPTH;
      r_credit_owed     <= PTR_ZERO;
    end else begin
      if (r_credit_init_cnt != PTR_ZERO) begin
        r_credit_init_cnt <= r_credit_init_cnt - PTR_ONE;
      end
      case ({w_load, w_send_owed})
        2'b10:   r_credit_owed <= r_credit_owed + PTR_ONE;
        2'b01:   r_credit_owed <= r_credit_owed - PTR_ONE;
        default: r_credit_owed <= r_credit_owed;
      endcase
    end
  end

  assign o_afu_valid        = r_afu_valid;
  assign o_cfg_valid        = r_cfg_valid;
  assign o_out_data         = r_out_data;
  assign o_overflow_err     = r_overflow_err;
  assign o_rcv_xmt_credit_v = w_credit_v;
  assign o_fifo_count       = r_cm_ptr - r_rd_ptr;

endmodule

// File: tb/tb_ocx_tlx_cmd_fifo_mac_gen2.sv
// Directed self-checking bench for ocx_tlx_cmd_fifo_mac_gen2 (default parameters).
module tb_ocx_tlx_cmd_fifo_mac_gen2;

  localparam int DW = 168;
  localparam int AW = 6;

  logic          tlx_clk = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_commit;
  logic          crc_error;
  logic          afu_ready;
  logic          cfg_ready;
  logic          afu_valid;
  logic          cfg_valid;
  logic [DW-1:0] out_data;
  logic          credit_v;
  logic [AW:0]   fifo_count;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;
  int credit_cnt = 0;

  ocx_tlx_cmd_fifo_mac_gen2 dut (
    .tlx_clk            (tlx_clk),
    .reset_n            (reset_n),
    .i_wr_valid         (wr_valid),
    .i_wr_data          (wr_data),
    .i_wr_commit        (wr_commit),
    .i_crc_error        (crc_error),
    .i_afu_ready        (afu_ready),
    .i_cfg_ready        (cfg_ready),
    .o_afu_valid        (afu_valid),
    .o_cfg_valid        (cfg_valid),
    .o_out_data         (out_data),
    .o_rcv_xmt_credit_v (credit_v),
    .o_fifo_count       (fifo_count),
    .o_overflow_err     (overflow_err)
  );

  always #5 tlx_clk = ~tlx_clk;

  // Pulses actually delivered to the transmit side
  always @(posedge tlx_clk) begin
    if (!reset_n) credit_cnt <= 0;
    else if (credit_v) credit_cnt <= credit_cnt + 1;
  end

  function automatic logic [DW-1:0] mk(input logic [7:0] opc, input int tag);
    return {160'(tag), opc};
  endfunction

  task automatic tick();
    @(posedge tlx_clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_data = '0; wr_commit = 1'b0; crc_error = 1'b0;
  endtask

  task automatic check_burst(input string name);
    int  hi = 0;
    bit  seen_low = 1'b0;
    bit  gap = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (credit_v) begin
        hi++;
        if (seen_low) gap = 1'b1;
      end else begin
        seen_low = 1'b1;
      end
      tick();
    end
    checks++;
    if (hi !== 64 || gap) begin
      errors++;
      $display("FAIL %s: got %0d pulses (gap=%0d), expected 64 consecutive", name, hi, gap);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle_inputs(); afu_ready = 1'b0; cfg_ready = 1'b0;
    tick(); tick();
    checks++; if ({afu_valid, cfg_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", {afu_valid, cfg_valid}); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (fifo_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_err); end
    reset_n = 1'b1;
    check_burst("reset_burst");
  endtask

  task automatic test_afu_stream();
    int base = credit_cnt;
    afu_ready = 1'b1; cfg_ready = 1'b0;
    wr_valid = 1'b1; wr_data = mk(8'h20, 1); tick();
    wr_data = mk(8'h20, 2); tick();
    wr_data = mk(8'h20, 3); wr_commit = 1'b1; tick();
    idle_inputs();
    checks++; if (fifo_count !== 7'd3) begin errors++; $display("FAIL afu_count: got %0d expected 3", fifo_count); end
    checks++; if (afu_valid !== 1'b0) begin errors++; $display("FAIL afu_early: got %b expected 0", afu_valid); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({afu_valid, cfg_valid} !== 2'b10 || out_data !== mk(8'h20, k)) begin
        errors++;
        $display("FAIL afu_beat%0d: got v=%b d=%h expected v=10 d=%h", k, {afu_valid, cfg_valid}, out_data, mk(8'h20, k));
      end
    end
    tick();
    checks++; if ({afu_valid, cfg_valid} !== 2'b00) begin errors++; $display("FAIL afu_end: got %b expected 00", {afu_valid, cfg_valid}); end
    repeat (4) tick();
    checks++; if (credit_cnt - base !== 3) begin errors++; $display("FAIL afu_credits: got %0d expected 3", credit_cnt - base); end
  endtask

  task automatic test_cfg_hold();
    int base = credit_cnt;
    afu_ready = 1'b0; cfg_ready = 1'b0;
    wr_valid = 1'b1; wr_data = mk(8'hE1, 7); tick();
    wr_data = mk(8'h20, 8); wr_commit = 1'b1; tick();
    idle_inputs(); tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({afu_valid, cfg_valid} !== 2'b01 || out_data !== mk(8'hE1, 7) || fifo_count !== 7'd1) begin
        errors++;
        $display("FAIL cfg_hold%0d: got v=%b d=%h n=%0d expected v=01 d=%h n=1", c, {afu_valid, cfg_valid}, out_data, fifo_count, mk(8'hE1, 7));
      end
      if (c < 4) tick();
    end
    checks++; if (credit_cnt - base !== 1) begin errors++; $display("FAIL cfg_hold_credit: got %0d expected 1", credit_cnt - base); end
    cfg_ready = 1'b1; afu_ready = 1'b1; tick();
    checks++;
    if ({afu_valid, cfg_valid} !== 2'b10 || out_data !== mk(8'h20, 8) || fifo_count !== 7'd0) begin
      errors++;
      $display("FAIL cfg_next: got v=%b d=%h n=%0d expected v=10 d=%h n=0", {afu_valid, cfg_valid}, out_data, fifo_count, mk(8'h20, 8));
    end
    tick();
    checks++; if ({afu_valid, cfg_valid} !== 2'b00) begin errors++; $display("FAIL cfg_end: got %b expected 00", {afu_valid, cfg_valid}); end
    repeat (4) tick();
    checks++; if (credit_cnt - base !== 2) begin errors++; $display("FAIL cfg_credits: got %0d expected 2", credit_cnt - base); end
  endtask

  task automatic test_rollback();
    logic [DW-1:0] exp_q [3];
    exp_q[0] = mk(8'h20, 11); exp_q[1] = mk(8'h20, 12); exp_q[2] = mk(8'h20, 16);
    afu_ready = 1'b0; cfg_ready = 1'b0;
    wr_valid = 1'b1; wr_data = mk(8'h20, 11); tick();
    wr_data = mk(8'h20, 12); wr_commit = 1'b1; tick();
    wr_commit = 1'b0;
    checks++; if (fifo_count !== 7'd2) begin errors++; $display("FAIL rb_count: got %0d expected 2", fifo_count); end
    wr_data = mk(8'h20, 13); tick();
    wr_data = mk(8'h20, 14); tick();
    wr_data = mk(8'h20, 15); tick();
    wr_data = mk(8'h20, 99); wr_commit = 1'b1; crc_error = 1'b1; tick();
    crc_error = 1'b0; wr_data = mk(8'h20, 16); tick();
    idle_inputs();
    checks++; if (fifo_count !== 7'd2) begin errors++; $display("FAIL rb_count_after: got %0d expected 2", fifo_count); end
    afu_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (afu_valid !== 1'b1 || out_data !== exp_q[k]) begin
        errors++;
        $display("FAIL rb_beat%0d: got v=%b d=%h expected v=1 d=%h", k, afu_valid, out_data, exp_q[k]);
      end
      tick();
    end
    checks++; if ({afu_valid, cfg_valid} !== 2'b00) begin errors++; $display("FAIL rb_end: got %b expected 00", {afu_valid, cfg_valid}); end
  endtask

  task automatic test_overflow();
    int base = credit_cnt;
    int beats = 0;
    afu_ready = 1'b0; cfg_ready = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr_data = mk(8'h20, 100 + i); tick();
    end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow_err); end
    wr_data = mk(8'h20, 999); tick();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
    wr_valid = 1'b0; wr_commit = 1'b1; tick();
    idle_inputs();
    checks++; if (fifo_count !== 7'd64 || afu_valid !== 1'b0) begin errors++; $display("FAIL ovf_count: got n=%0d v=%b expected n=64 v=0", fifo_count, afu_valid); end
    tick();
    afu_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (afu_valid) begin
        checks++;
        if (out_data !== mk(8'h20, 100 + beats)) begin
          errors++;
          $display("FAIL ovf_beat%0d: got %h expected %h", beats, out_data, mk(8'h20, 100 + beats));
        end
        beats++;
      end
      tick();
    end
    checks++; if (beats !== 64) begin errors++; $display("FAIL ovf_beats: got %0d expected 64", beats); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
    repeat (4) tick();
    checks++; if (credit_cnt - base !== 64) begin errors++; $display("FAIL ovf_credits: got %0d expected 64", credit_cnt - base); end
  endtask

  task automatic test_reset_mid();
    afu_ready = 1'b0; cfg_ready = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = mk(8'h20, 200 + i); wr_commit = (i == 9); tick();
    end
    idle_inputs(); tick(); tick();
    checks++; if (fifo_count !== 7'd9 || afu_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got n=%0d v=%b expected n=9 v=1", fifo_count, afu_valid); end
    reset_n = 1'b0; tick();
    checks++;
    if ({afu_valid, cfg_valid} !== 2'b00 || fifo_count !== 7'd0 || overflow_err !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b n=%0d ovf=%b d=%h expected all 0", {afu_valid, cfg_valid}, fifo_count, overflow_err, out_data);
    end
    reset_n = 1'b1;
    check_burst("mid_burst");
    checks++; if (afu_valid !== 1'b0 || fifo_count !== 7'd0) begin errors++; $display("FAIL mid_empty: got v=%b n=%0d expected 0 0", afu_valid, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_afu_stream();
    test_cfg_hold();
    test_rollback();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
